// File: rtl/sd_spi_engine_pkg.sv
// Shared constants for the SD-card SPI byte-burst engine: FSM encodings,
// the SD idle/fill byte, sector size and divider counter width.
package sd_spi_engine_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [7:0] SD_IDLE_BYTE    = 8'hFF;
    localparam int         SD_SECTOR_BYTES = 512;

    localparam int DIV_W = 16;

endpackage

// File: rtl/sd_spi_engine_if.sv
// User-side handshake bundle of the SPI engine: burst request/config going in,
// received bytes and status pulses coming back.
interface sd_spi_engine_if
    import sd_spi_engine_pkg::*;
#(
    parameter int CS_W  = 1,
    parameter int LEN_W = 10
);
    logic             start;
    logic             abort;
    logic [CS_W-1:0]  cs_sel;
    logic             fast;
    logic             cs_off;
    logic             keep_cs;
    logic [LEN_W-1:0] burst_len;
    logic [7:0]       tx_byte;
    logic [7:0]       rx_byte;
    logic             byte_done;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, cs_sel, fast, cs_off, keep_cs, burst_len, tx_byte,
        input  rx_byte, byte_done, busy, done
    );

    modport slave (
        input  start, abort, cs_sel, fast, cs_off, keep_cs, burst_len, tx_byte,
        output rx_byte, byte_done, busy, done
    );
endinterface

// File: rtl/sd_spi_engine_clk_div.sv
// Loadable half-period counter: emits a one-cycle tick every div_i cycles,
// restarting its count whenever clear_i is high.
module sd_spi_clk_div
    import sd_spi_engine_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == div_i - DIV_W'(1));

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_spi_engine.sv
// Mode-0 SPI byte-burst engine for SD cards: N chip selects, slow/fast clock,
// continuous multi-byte bursts with per-byte handshake, CS parking and abort.
module sd_spi_engine
    import sd_spi_engine_pkg::*;
#(
    parameter int SLOW_DIV = 125,
    parameter int FAST_DIV = 2,
    parameter int NUM_CS   = 1,
    parameter int CS_W     = 1,
    parameter int LEN_W    = 10
) (
    input  logic              clk,
    input  logic              btn,
    sd_spi_engine_if.slave    bus,
    input  logic              miso_i,
    output logic              spi_clk_o,
    output logic              mosi_o,
    output logic [NUM_CS-1:0] cs_o
);

    localparam logic [DIV_W-1:0] SLOW_D = DIV_W'(SLOW_DIV);
    localparam logic [DIV_W-1:0] FAST_D = DIV_W'(FAST_DIV);

    logic [1:0]        state_q, state_d;
    logic              fast_q, fast_d;
    logic              keep_q, keep_d;
    logic [NUM_CS-1:0] cs_q, cs_d;
    logic [7:0]        tx_q, tx_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic [2:0]        bit_q, bit_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              spi_clk_q, spi_clk_d;
    logic              byte_done_q, byte_done_d;
    logic              done_q, done_d;
    logic              div_clear;
    logic              tick;

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] r;
        for (int i = 0; i < NUM_CS; i++) begin
            r[i] = (int'(sel) != i);
        end
        return r;
    endfunction

    sd_spi_clk_div u_div (
        .clk     (clk),
        .rst     (btn),
        .clear_i (div_clear),
        .div_i   (fast_q ? FAST_D : SLOW_D),
        .tick_o  (tick)
    );

    always_comb begin
        state_d     = state_q;
        fast_d      = fast_q;
        keep_d      = keep_q;
        cs_d        = cs_q;
        tx_d        = tx_q;
        rx_sh_d     = rx_sh_q;
        rx_byte_d   = rx_byte_q;
        bit_d       = bit_q;
        len_d       = len_q;
        spi_clk_d   = spi_clk_q;
        byte_done_d = 1'b0;
        done_d      = 1'b0;
        div_clear   = 1'b0;

        if (bus.abort) begin
            state_d   = ST_IDLE;
            cs_d      = '1;
            spi_clk_d = 1'b0;
            div_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d   = ST_SETUP;
                        div_clear = 1'b1;
                        fast_d    = bus.fast;
                        keep_d    = bus.keep_cs;
                        cs_d      = bus.cs_off ? '1 : cs_decode(bus.cs_sel);
                        tx_d      = bus.tx_byte;
                        len_d     = (bus.burst_len == '0) ? LEN_W'(1) : bus.burst_len;
                        bit_d     = 3'd7;
                        spi_clk_d = 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The next byte is taken at the edge closing the byte_done cycle.
                    if (byte_done_q) begin
                        tx_d = bus.tx_byte;
                    end
                    if (tick) begin
                        if (!spi_clk_q) begin
                            spi_clk_d = 1'b1;
                            rx_sh_d   = {rx_sh_q[6:0], miso_i};
                        end else begin
                            spi_clk_d = 1'b0;
                            if (bit_q == 3'd0) begin
                                rx_byte_d   = rx_sh_q;
                                byte_done_d = 1'b1;
                                len_d       = len_q - LEN_W'(1);
                                bit_d       = 3'd7;
                                if (len_q == LEN_W'(1)) begin
                                    state_d = ST_HOLD;
                                end
                            end else begin
                                bit_d = bit_q - 3'd1;
                                tx_d  = {tx_q[6:0], SD_IDLE_BYTE[0]};
                            end
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        if (!keep_q) begin
                            cs_d = '1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge btn) begin
        if (btn) begin
            state_q     <= ST_IDLE;
            fast_q      <= 1'b0;
            keep_q      <= 1'b0;
            cs_q        <= '1;
            tx_q        <= SD_IDLE_BYTE;
            rx_sh_q     <= 8'h00;
            rx_byte_q   <= 8'h00;
            bit_q       <= 3'd7;
            len_q       <= '0;
            spi_clk_q   <= 1'b0;
            byte_done_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fast_q      <= fast_d;
            keep_q      <= keep_d;
            cs_q        <= cs_d;
            tx_q        <= tx_d;
            rx_sh_q     <= rx_sh_d;
            rx_byte_q   <= rx_byte_d;
            bit_q       <= bit_d;
            len_q       <= len_d;
            spi_clk_q   <= spi_clk_d;
            byte_done_q <= byte_done_d;
            done_q      <= done_d;
        end
    end

    // During byte_done the low phase of the next byte has already begun, so its
    // MSB comes straight from the user's tx_byte until it is registered.
    always_comb begin
        mosi_o = SD_IDLE_BYTE[7];
        if (state_q == ST_SHIFT && byte_done_q) begin
            mosi_o = bus.tx_byte[7];
        end else if (state_q == ST_SETUP || state_q == ST_SHIFT) begin
            mosi_o = tx_q[7];
        end
    end

    assign spi_clk_o     = spi_clk_q;
    assign cs_o          = cs_q;
    assign bus.rx_byte   = rx_byte_q;
    assign bus.byte_done = byte_done_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
